// File: rtl/jmb_acc.sv
// jmb_acc: job-based accumulator for the unsigned 32-bit products coming out
// of the jmb_mad2 stage. A job is launched with start/len, consumes len
// products over a valid/ready handshake, then holds the sum until downstream
// takes it.
// Optional feature: define JMB_ACC_SAT_EN to saturate the accumulator to
// all-ones on overflow; by default it wraps modulo 2^ACC_W. ovf is raised in
// both builds.
module jmb_acc #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic               ovf_r, ovf_nxt;
    logic [ACC_W:0]     sum;

    // Saturating or wrapping update of the accumulator from the widened sum.
    function automatic logic [ACC_W-1:0] next_acc(input logic [ACC_W:0] s);
`ifdef JMB_ACC_SAT_EN
        // Once saturated, any further non-zero product carries again, so the
        // value stays pinned at all-ones for the rest of the job.
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    // One extra bit on top of the accumulator captures the carry-out.
    assign sum = {1'b0, acc} + {{(ACC_W - 31){1'b0}}, in_data};

    // Next-state, datapath update and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_r;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt = '0;
                    ovf_nxt = 1'b0;
                    if (len != '0) begin
                        cnt_nxt   = len;
                        state_nxt = ACCUM;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    acc_nxt = next_acc(sum);
                    if (sum[ACC_W]) begin
                        ovf_nxt = 1'b1;
                    end
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    assign out_data = acc;
    assign ovf      = ovf_r;

endmodule

// File: tb/tb_jmb_acc.sv
// Scoreboard bench for jmb_acc built with ACC_W=33 so overflow is reachable.
// Expected results come from a plain-arithmetic model of each job's total.
module tb_jmb_acc;
    localparam int AW = 33;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          ovf;

    jmb_acc #(.ACC_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] data;
        logic          ovf;
    } exp_t;

    exp_t            q[$];
    longint unsigned msum;
    int              errors = 0;
    int              checks = 0;

    // Reference result of a job whose products add up to s (exact integer).
    function automatic exp_t model(input longint unsigned s);
        exp_t e;
        longint unsigned lim;
        lim   = (64'd1 << AW) - 64'd1;
        e.ovf = (s > lim);
`ifdef JMB_ACC_SAT_EN
        e.data = e.ovf ? {AW{1'b1}} : AW'(s);
`else
        e.data = AW'(s & lim);
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents a result, compare it with the head.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 at %0t", $time);
            end else begin
                check("out_data", 64'(out_data), 64'(q[0].data));
                check("ovf", 64'(ovf), 64'(q[0].ovf));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        len   = LW'(n);
        msum  = 0;
        tick();
        start = 1'b0;
        if (n == 0) begin
            q.push_back(model(0));
            check("zero_len_valid", 64'(out_valid), 64'd1);
        end else begin
            check("accum_in_ready", 64'(in_ready), 64'd1);
        end
        check("job_busy", 64'(busy), 64'd1);
    endtask

    task automatic send(input logic [31:0] d, input int gaps, input bit last);
        in_valid = 1'b1;
        in_data  = d;
        msum     = msum + longint'(d);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        if (last) begin
            q.push_back(model(msum));
            check("latency_out_valid", 64'(out_valid), 64'd1);
        end else begin
            check("mid_in_ready", 64'(in_ready), 64'd1);
            repeat (gaps) tick();
        end
    endtask

    task automatic finish_job(input int hold, input bit poke);
        out_ready = 1'b0;
        repeat (hold) begin
            start = poke;
            len   = 8'd3;
            tick();
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        start     = poke;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; len = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        // Basic: 1+2+3
        do_start(3);
        send(32'd1, 0, 1'b0);
        send(32'd2, 0, 1'b0);
        send(32'd3, 0, 1'b1);
        check("basic_sum", 64'(out_data), 64'd6);
        finish_job(0, 1'b0);

        // Gaps, backpressure, start poked in HOLD and in the handshake cycle
        do_start(2);
        send(32'h10, 3, 1'b0);
        send(32'h20, 0, 1'b1);
        finish_job(5, 1'b1);

        // Zero length
        do_start(0);
        check("zero_len_data", 64'(out_data), 64'd0);
        finish_job(1, 1'b0);

        // Overflow at ACC_W=33
        do_start(3);
        repeat (2) send(32'hFFFF_FFFF, 0, 1'b0);
        send(32'hFFFF_FFFF, 0, 1'b1);
`ifdef JMB_ACC_SAT_EN
        check("ovf_sum", 64'(out_data), 64'h1_FFFF_FFFF);
`else
        check("ovf_sum", 64'(out_data), 64'h0_FFFF_FFFD);
`endif
        check("ovf_flag", 64'(ovf), 64'd1);
        finish_job(2, 1'b0);

        // Reset mid-job, with start and in_valid also asserted
        do_start(4);
        send(32'd1, 0, 1'b0);
        send(32'd2, 0, 1'b0);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 32'd7;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_acc", 64'(out_data), 64'd0);
        check("midrst_ovf", 64'(ovf), 64'd0);
        repeat (3) tick();
        check("midrst_no_valid", 64'(out_valid), 64'd0);

        // Reset beats start from IDLE
        rst = 1'b1; start = 1'b1; len = 8'd3;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_over_start", 64'(busy), 64'd0);

        do_start(1);
        send(32'd5, 0, 1'b1);
        check("after_rst_sum", 64'(out_data), 64'd5);
        finish_job(0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 30; j++) begin
            n = $urandom_range(0, 6);
            do_start(n);
            for (int i = 0; i < n; i++) begin
                logic [31:0] d;
                d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                send(d, $urandom_range(0, 2), (i == n - 1));
            end
            finish_job($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jmb_acc.md
JMB_ACC -- requirements
Module: jmb_acc

Interface
REQ-001 Parameter ACC_W, default 40: accumulator and result width; legal range 32..64.
REQ-002 Parameter LEN_W, default 8: width of the product-count input.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: one-cycle request to begin a new accumulation; sampled only in IDLE.
REQ-006 Port len, input, LEN_W: number of products to accumulate; sampled with start.
REQ-007 Port in_data, input, 32: unsigned product from the upstream jmb_mad2 stage.
REQ-008 Port in_valid, input, 1: in_data is valid.
REQ-009 Port in_ready, output, 1: block accepts in_data this cycle.
REQ-010 Port out_data, output, ACC_W: accumulated sum.
REQ-011 Port out_valid, output, 1: out_data is valid.
REQ-012 Port out_ready, input, 1: downstream consumes out_data.
REQ-013 Port busy, output, 1: block is not in IDLE.
REQ-014 Port ovf, output, 1: sticky flag; the current job exceeded ACC_W bits.

Function
REQ-015 The block SHALL implement three states: IDLE, ACCUM and HOLD.
REQ-016 IDLE: in_ready=0, out_valid=0, busy=0.
- start=1 with len!=0: clear acc, ovf; load cnt=len; next state ACCUM.
- start=1 with len==0: clear acc, ovf; next state HOLD.
REQ-017 ACCUM: in_ready=1, busy=1.
- A transfer occurs when in_valid and in_ready are both 1.
- On transfer: acc += zero-extended in_data; cnt -= 1.
- A cycle with in_valid=0 leaves acc and cnt unchanged.
REQ-018 A transfer with cnt==1 SHALL move the block to HOLD on the next cycle.
REQ-019 Latency: out_valid rises exactly one cycle after the final transfer, with out_data equal to the complete sum.
REQ-020 HOLD: out_valid=1, busy=1, in_ready=0.
- out_data and ovf stay stable until out_ready=1.
- out_valid && out_ready returns the block to IDLE next cycle.
REQ-021 start asserted outside IDLE SHALL be ignored, including in the handshake cycle of HOLD.
REQ-022 out_data SHALL equal the acc register in every state; it is registered with no combinational path from inputs.
REQ-023 A carry out of bit ACC_W-1 on any transfer SHALL set ovf; ovf stays set until the next accepted start or rst.
REQ-024 Default parameters SHALL be overflow-free, since 255 x (2^32-1) < 2^40.

Reset
REQ-025 rst=1 SHALL force, on the next edge, regardless of state or mid-job:
- state=IDLE
- acc=0, cnt=0
- out_valid=0, in_ready=0, busy=0, ovf=0
REQ-026 A job in progress when rst is asserted SHALL be discarded; no out_valid is produced for it.
REQ-027 rst SHALL take priority over start, in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro JMB_ACC_SAT_EN defined: on overflow, acc SHALL saturate to all-ones (2^ACC_W-1) and hold there for the rest of the job; ovf is set.
REQ-029 Macro JMB_ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf is still set.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Basic: start, len=3; in_data 1, 2, 3 with in_valid continuous -> out_valid one cycle after the third transfer, out_data=6, ovf=0.
- Gaps and backpressure: len=2; in_data 0x10, then 3 idle cycles, then 0x20; out_ready held low 5 cycles; start pulsed during HOLD -> out_data=0x30 stable for all 5 cycles, start ignored, IDLE one cycle after out_ready=1.
- Zero length: start, len=0 -> out_valid=1, out_data=0 on the next cycle.
- Overflow, ACC_W=33: len=3, in_data 0xFFFFFFFF x3 -> without macro out_data=0x0FFFFFFFD; with macro out_data=0x1FFFFFFFF; ovf=1 in both.
- Reset mid-job: len=4, two transfers, then rst=1 for one cycle -> next cycle IDLE, acc=0, busy=0, no out_valid; a new job with len=1, in_data 5 -> out_data=5.
